// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the instruction/data memory port arbiter.
package mem_arb_pkg;

  typedef enum logic {
    IDLE,
    RMW_WR
  } state_t;

  localparam int         DEFAULT_MEM_BYTES = 1024;
  localparam logic [3:0] BE_WORD           = 4'b1111;

  function automatic logic [31:0] beToMask(input logic [3:0] be);
    logic [31:0] mask;
    for (int i = 0; i < 4; i++) begin
      mask[8*i +: 8] = {8{be[i]}};
    end
    return mask;
  endfunction

endpackage

// File: rtl/byte_merge.sv
// Combinational byte-lane merge of a new store word into the old memory word.
module byte_merge
  import mem_arb_pkg::*;
(
  input  logic [31:0] i_oldWord,
  input  logic [31:0] i_newWord,
  input  logic [3:0]  i_be,
  output logic [31:0] o_merged
);

  logic [31:0] w_mask;

  assign w_mask   = beToMask(i_be);
  assign o_merged = (i_oldWord & ~w_mask) | (i_newWord & w_mask);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one word-wide memory between fetch and data stages; partial
// stores become read-modify-write sequences, with registered responses.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MEM_BYTES    = DEFAULT_MEM_BYTES,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rsp_valid,
  output logic [31:0] if_rsp_data,
  output logic        if_rsp_err,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [3:0]  d_be,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rsp_valid,
  output logic [31:0] d_rsp_data,
  output logic        d_rsp_err,
  output logic [31:0] mem_address,
  output logic [31:0] mem_writeData,
  output logic        mem_memWrite,
  input  logic [31:0] mem_readData
);

  localparam logic [3:0]  STARVE_MAX = 4'(STARVE_LIMIT);
  localparam logic [31:0] MEM_LIMIT  = 32'(MEM_BYTES);

  state_t      r_state;
  state_t      w_nextState;
  logic [3:0]  r_starveCnt;
  logic [31:0] r_rmwAddr;
  logic [31:0] r_merged;
  logic        r_ifRspValid;
  logic [31:0] r_ifRspData;
  logic        r_ifRspErr;
  logic        r_dRspValid;
  logic [31:0] r_dRspData;
  logic        r_dRspErr;

  logic [31:0] w_dAligned;
  logic        w_dWordAcc;
  logic        w_dZeroBe;
  logic        w_dPartial;
  logic        w_dErr;
  logic        w_ifErr;
  logic        w_fetchFirst;
  logic        w_rmwStart;
  logic [31:0] w_merged;

  assign w_dAligned   = {d_addr[31:2], 2'b00};
  assign w_dWordAcc   = !d_we || (d_be == BE_WORD);
  assign w_dZeroBe    = d_we && (d_be == 4'b0000);
  assign w_dPartial   = d_we && !w_dWordAcc && !w_dZeroBe;
  assign w_dErr       = w_dWordAcc ? ((d_addr[1:0] != 2'b00) || (d_addr >= MEM_LIMIT))
                                   : (w_dPartial && (w_dAligned >= MEM_LIMIT));
  assign w_ifErr      = (if_addr[1:0] != 2'b00) || (if_addr >= MEM_LIMIT);
  assign w_fetchFirst = if_req && (r_starveCnt == STARVE_MAX);
  assign w_rmwStart   = d_gnt && w_dPartial && !w_dErr;

  byte_merge u_merge (
    .i_oldWord (mem_readData),
    .i_newWord (d_wdata),
    .i_be      (d_be),
    .o_merged  (w_merged)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (w_rmwStart) w_nextState = RMW_WR;
      RMW_WR:  w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // Grants and memory drive; an erroring or be=0 access never touches memory.
  always_comb begin
    if_gnt        = 1'b0;
    d_gnt         = 1'b0;
    mem_address   = 32'h0;
    mem_writeData = 32'h0;
    mem_memWrite  = 1'b0;
    if (rst_n) begin
      if (r_state == RMW_WR) begin
        mem_address   = r_rmwAddr;
        mem_writeData = r_merged;
        mem_memWrite  = 1'b1;
      end else begin
        if (if_req && (w_fetchFirst || !d_req)) begin
          if_gnt = 1'b1;
        end else if (d_req) begin
          d_gnt = 1'b1;
        end
        if (if_gnt && !w_ifErr) begin
          mem_address = if_addr;
        end else if (d_gnt && !w_dErr && !w_dZeroBe) begin
          if (w_dPartial) begin
            mem_address = w_dAligned;
          end else begin
            mem_address = d_addr;
            if (d_we) begin
              mem_writeData = d_wdata;
              mem_memWrite  = 1'b1;
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_starveCnt <= 4'd0;
    end else if (if_gnt) begin
      r_starveCnt <= 4'd0;
    end else if (if_req && (r_starveCnt < STARVE_MAX)) begin
      r_starveCnt <= r_starveCnt + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rmwAddr <= 32'h0;
      r_merged  <= 32'h0;
    end else if (w_rmwStart) begin
      r_rmwAddr <= w_dAligned;
      r_merged  <= w_merged;
    end
  end

  // A partial store answers from the RMW_WR cycle, not from its grant cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ifRspValid <= 1'b0;
      r_ifRspData  <= 32'h0;
      r_ifRspErr   <= 1'b0;
      r_dRspValid  <= 1'b0;
      r_dRspData   <= 32'h0;
      r_dRspErr    <= 1'b0;
    end else begin
      r_ifRspValid <= if_gnt;
      r_ifRspErr   <= if_gnt && w_ifErr;
      r_ifRspData  <= (if_gnt && !w_ifErr) ? mem_readData : 32'h0;
      if (r_state == RMW_WR) begin
        r_dRspValid <= 1'b1;
        r_dRspErr   <= 1'b0;
        r_dRspData  <= 32'h0;
      end else begin
        r_dRspValid <= d_gnt && !w_rmwStart;
        r_dRspErr   <= d_gnt && w_dErr;
        r_dRspData  <= (d_gnt && !d_we && !w_dErr) ? mem_readData : 32'h0;
      end
    end
  end

  assign if_rsp_valid = r_ifRspValid;
  assign if_rsp_data  = r_ifRspData;
  assign if_rsp_err   = r_ifRspErr;
  assign d_rsp_valid  = r_dRspValid;
  assign d_rsp_data   = r_dRspData;
  assign d_rsp_err    = r_dRspErr;

endmodule
